// File: rtl/mod_n_counter.sv
// mod_n_counter: modulo-N counter with a run-time modulus, up/down counting,
// count enable, synchronous load and registered wrap flags. The combinational
// terminal count lets instances be chained into multi-digit counters.
//
// Parameters:
//   WIDTH       counter width in bits (2..16)
//   DEFAULT_MOD modulus used when mod_val < 2 (2..2^WIDTH-1)
//   WRAP_CNT_W  width of wrap_cnt (used only with the macro below)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         count enable, one step per edge
//   up_dn      1 = up, 0 = down
//   load       synchronous load strobe; has priority over en
//   load_val   value to load, clamped to N-1
//   mod_val    run-time modulus N
//   count      registered count
//   overflow   registered pulse while count shows the value after an up-wrap
//   underflow  registered pulse while count shows the value after a down-wrap
//   tc         combinational terminal count: en & (up ? count >= N-1 : count == 0)
//   wrap_cnt   saturating wrap-event count (only with the macro below)
//
// Optional feature: define MOD_N_COUNTER_WRAP_CNT_EN to build the wrap_cnt
// port and its counter.

module mod_n_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DEFAULT_MOD = 10,
    parameter int unsigned WRAP_CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             tc
`ifdef MOD_N_COUNTER_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

    localparam logic [WIDTH-1:0] DEF_MOD = WIDTH'(DEFAULT_MOD);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("mod_n_counter: WIDTH out of range");
    end
    if (DEFAULT_MOD < 2 || DEFAULT_MOD > (2 ** WIDTH) - 1) begin : g_bad_default
        $error("mod_n_counter: DEFAULT_MOD out of range");
    end
    if (WRAP_CNT_W < 1) begin : g_bad_wrap_w
        $error("mod_n_counter: WRAP_CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    assign modulus = (mod_val >= WIDTH'(2)) ? mod_val : DEF_MOD;
    assign term    = modulus - WIDTH'(1);

    // Up uses >= so a count left above a shrunk modulus still wraps to 0.
    assign tc = en & (up_dn ? (count >= term) : (count == '0));

    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (load) begin
            count_nxt = (load_val > term) ? term : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (count >= term) begin
                    count_nxt = '0;
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    count_nxt = term;
                    unf_nxt   = 1'b1;
                end else if (count > term) begin
                    // Out-of-range after a modulus cut: settle at T, no wrap event.
                    count_nxt = term;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

`ifdef MOD_N_COUNTER_WRAP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_cnt <= '0;
        end else if (load) begin
            wrap_cnt <= '0;
        end else if ((ovf_nxt || unf_nxt) && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] c;
        logic         o;
        logic         u;
        logic [1:0]   wc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] mod_val = '0;
    logic [W-1:0] count;
    logic         overflow, underflow, tc;
`ifdef MOD_N_COUNTER_WRAP_CNT_EN
    logic [1:0]   wrap_cnt;
    logic [7:0]   d0_wc, d1_wc;
`endif

    // cascade pair
    logic         c_rst = 1'b1;
    logic         c_en = 1'b0;
    logic [W-1:0] d0_count, d1_count;
    logic         d0_ovf, d0_unf, d0_tc, d1_ovf, d1_unf, d1_tc;

    int n_vec = 0;
    int n_err = 0;
    string phase = "reset";
    exp_t q[$];

    // reference model state
    logic [W-1:0] m_c = '0;
    logic [1:0]   m_wc = '0;

    always #5 clk = ~clk;

    mod_n_counter #(.WIDTH(W), .DEFAULT_MOD(10), .WRAP_CNT_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_val(mod_val), .count(count),
        .overflow(overflow), .underflow(underflow), .tc(tc)
`ifdef MOD_N_COUNTER_WRAP_CNT_EN
        , .wrap_cnt(wrap_cnt)
`endif
    );

    mod_n_counter #(.WIDTH(W), .DEFAULT_MOD(10), .WRAP_CNT_W(8)) d0 (
        .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .mod_val(4'd10), .count(d0_count),
        .overflow(d0_ovf), .underflow(d0_unf), .tc(d0_tc)
`ifdef MOD_N_COUNTER_WRAP_CNT_EN
        , .wrap_cnt(d0_wc)
`endif
    );

    mod_n_counter #(.WIDTH(W), .DEFAULT_MOD(10), .WRAP_CNT_W(8)) d1 (
        .clk(clk), .rst(c_rst), .en(d0_tc), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .mod_val(4'd10), .count(d1_count),
        .overflow(d1_ovf), .underflow(d1_unf), .tc(d1_tc)
`ifdef MOD_N_COUNTER_WRAP_CNT_EN
        , .wrap_cnt(d1_wc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus (called just after a rising edge), check tc
    // combinationally, push the model's next state, then compare after the edge.
    task automatic apply(input logic e, input logic u, input logic l,
                         input logic [W-1:0] lv, input logic [W-1:0] mv);
        exp_t x, got;
        logic [W-1:0] t;
        en = e; up_dn = u; load = l; load_val = lv; mod_val = mv;
        #1;
        t = ((mv >= 2) ? mv : W'(10)) - W'(1);
        chk("tc", {31'd0, tc}, {31'd0, e & (u ? (m_c >= t) : (m_c == 0))});
        x.o = 1'b0;
        x.u = 1'b0;
        x.c = m_c;
        if (l) begin
            x.c = (lv > t) ? t : lv;
            m_wc = '0;
        end else if (e) begin
            if (u) begin
                if (m_c >= t) begin x.c = '0; x.o = 1'b1; end
                else x.c = m_c + W'(1);
            end else begin
                if (m_c == 0) begin x.c = t; x.u = 1'b1; end
                else if (m_c > t) x.c = t;
                else x.c = m_c - W'(1);
            end
        end
        if ((x.o || x.u) && m_wc != 2'b11) m_wc = m_wc + 2'd1;
        x.wc = m_wc;
        m_c = x.c;
        q.push_back(x);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("count", {28'd0, count}, {28'd0, got.c});
        chk("overflow", {31'd0, overflow}, {31'd0, got.o});
        chk("underflow", {31'd0, underflow}, {31'd0, got.u});
`ifdef MOD_N_COUNTER_WRAP_CNT_EN
        chk("wrap_cnt", {30'd0, wrap_cnt}, {30'd0, got.wc});
`endif
    endtask

    initial begin
        int pulses;
        // reset values; tc is 1 with en=1, down, count=0 even in reset
        en = 1'b1; up_dn = 1'b0;
        #2;
        chk("count", {28'd0, count}, 32'd0);
        chk("overflow", {31'd0, overflow}, 32'd0);
        chk("underflow", {31'd0, underflow}, 32'd0);
        chk("tc_down", {31'd0, tc}, 32'd1);
`ifdef MOD_N_COUNTER_WRAP_CNT_EN
        chk("wrap_cnt", {30'd0, wrap_cnt}, 32'd0);
`endif
        en = 1'b0; up_dn = 1'b1;
        #1;
        chk("tc_idle", {31'd0, tc}, 32'd0);
        #5;
        rst = 1'b0;

        phase = "default_up";
        repeat (12) apply(1, 1, 0, 0, 0);

        phase = "down_mod6";
        apply(0, 1, 1, 0, 6);
        repeat (3) apply(1, 0, 0, 0, 6);

        phase = "load";
        apply(0, 1, 1, 13, 12);
        apply(1, 1, 1, 3, 12);
        phase = "mod1_default";
        apply(1, 1, 0, 0, 1);

        phase = "mod_cut";
        apply(0, 1, 1, 8, 10);
        apply(1, 1, 0, 0, 5);
        apply(0, 1, 1, 8, 10);
        apply(1, 0, 0, 0, 5);
        phase = "idle";
        apply(0, 1, 0, 0, 5);
        apply(0, 0, 0, 0, 5);

        phase = "reverse";
        apply(0, 1, 1, 4, 5);
        apply(1, 1, 0, 0, 5);
        apply(1, 0, 0, 0, 5);
        apply(1, 1, 0, 0, 5);

        phase = "n2_wrap";
        apply(0, 1, 1, 0, 2);
        repeat (8) apply(1, 1, 0, 0, 2);
        apply(0, 1, 1, 1, 2);
        repeat (2) apply(1, 0, 0, 0, 2);
        apply(1, 1, 0, 0, 15);
        repeat (2) apply(1, 0, 0, 0, 15);

        phase = "async_rst";
        apply(0, 1, 1, 7, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("count", {28'd0, count}, 32'd0);
        chk("underflow", {31'd0, underflow}, 32'd0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_c = '0;
        m_wc = '0;
        apply(1, 1, 0, 0, 0);

        phase = "cascade";
        c_rst = 1'b0;
        chk("pair_start", {24'd0, d1_count, d0_count}, 32'd0);
        c_en = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            chk("ones", {28'd0, d0_count}, k % 10);
            chk("tens", {28'd0, d1_count}, (k / 10) % 10);
            chk("d1_ovf", {31'd0, d1_ovf}, {31'd0, k == 100});
            if (d1_ovf) pulses++;
            if (k == 99) chk("d1_tc_at_99", {31'd0, d1_tc}, 32'd1);
        end
        chk("d1_ovf_pulses", pulses, 32'd1);
        chk("d1_unf", {31'd0, d1_unf}, 32'd0);
        chk("d0_unf", {31'd0, d0_unf}, 32'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("pair_115", {24'd0, d1_count, d0_count}, 32'h15);
        #3;
        c_rst = 1'b1;
        #1;
        chk("ones_async", {28'd0, d0_count}, 32'd0);
        chk("tens_async", {28'd0, d1_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised modulo-N counter, the successor to the fixed mod-10 counter. Modulus is selectable at run time, with up/down counting, count enable, synchronous load and registered wrap flags. A combinational terminal-count output lets instances be cascaded into multi-digit counters (BCD, time-of-day, frame/line counters). An optional saturating wrap-event counter can be compiled in.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- DEFAULT_MOD, 10, modulus used when mod_val < 2; legal range 2..2^WIDTH-1.
- WRAP_CNT_W, 8, width of wrap_cnt; only used when the macro is defined.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, asynchronous and active-high.
- en  input  1  count enable; one step per clk edge while high.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load = 1.
- mod_val  input  WIDTH  run-time modulus N.
- count  output  WIDTH  current count, registered.
- overflow  output  1  registered one-cycle pulse after an up-wrap.
- underflow  output  1  registered one-cycle pulse after a down-wrap.
- tc  output  1  combinational terminal count, for cascading.
- wrap_cnt  output  WRAP_CNT_W  saturating wrap-event count; present only with the macro.

## Operation
- Effective modulus: N = mod_val if mod_val ≥ 2, else DEFAULT_MOD. Terminal value T = N-1. All compares are unsigned at WIDTH bits.
- Priority per edge is rst > load > en. If load and en are both high, load wins.
- Load:
  - count <= min(load_val, T); out-of-range values clamp to T.
  - overflow <= 0, underflow <= 0.
- Enabled, up (up_dn = 1):
  - count ≥ T: count <= 0, overflow <= 1.
  - Otherwise: count <= count+1, overflow <= 0.
  - underflow <= 0 in both cases.
- Enabled, down (up_dn = 0):
  - count = 0: count <= T, underflow <= 1.
  - count > T: count <= T, no flag.
  - Otherwise: count <= count-1.
  - overflow <= 0 in all cases.
- Idle (en = 0, load = 0): count holds; overflow <= 0, underflow <= 0.
- Run-time modulus change:
  - Takes effect on the next edge.
  - An out-of-range count is never an error. The next enabled step resolves it per the rules above: up wraps to 0 with overflow; down goes to T without a flag.
- tc = en & (up_dn ? (count ≥ T) : (count = 0)).
  - Cascade: drive the next digit's en from this digit's tc.
  - tc is never registered.

## Timing
- Reset values: count = 0, overflow = 0, underflow = 0, tc = 0 unless en = 1 and up_dn = 0, wrap_cnt = 0.
- Reset asserted mid-count clears all registers immediately, without waiting for a clock edge.
- On the first edge after rst deasserts, normal operation applies.
- count and the flags have one-cycle latency from en, load and up_dn.
- overflow and underflow are high for exactly the cycle in which count shows the wrapped value (0 or T). They are low in the following cycle unless another wrap occurs.
  - Consequence: with N = 2 and en held high, overflow stays high on alternating cycles.
- tc has zero latency: it is valid in the same cycle as count, en, up_dn and mod_val.
- Direction reversal at a boundary follows the rules for the new direction; there is no hysteresis.

## Configuration
- Macro: MOD_N_COUNTER_WRAP_CNT_EN.
- Defined:
  - wrap_cnt port exists.
  - It increments on every edge that sets overflow or underflow.
  - It saturates at all-ones.
  - It is cleared by rst and by load.
- Undefined: wrap_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
1. Defaults, mod_val = 0, en = 1, up:
   - Release rst, run 12 cycles.
   - count goes 0..9 then 0.
   - overflow = 1 only while count = 0 after the 9→0 edge; tc = 1 while count = 9.
2. Down count, mod_val = 6, up_dn = 0:
   - From count = 0, one edge gives count = 5 and underflow = 1.
   - The next edges give 4, 3 with underflow = 0.
3. Load:
   - load_val = 13 with mod_val = 12: count = 11.
   - load = 1 and en = 1 together with load_val = 3: count = 3, no flags.
4. Run-time modulus cut, count = 8, mod_val changed 10→5:
   - Next up edge: count = 0, overflow = 1.
   - Repeat from 8 counting down: count = 4, no flag.
5. Cascade, two instances with N = 10:
   - Digit 1 en = digit 0 tc. Run 100 cycles.
   - Pair reads 99 then 00; digit 1 overflow pulses once.
   - Assert rst asynchronously mid-cycle: both counts are 0 before the next edge.
6. With MOD_N_COUNTER_WRAP_CNT_EN defined, WRAP_CNT_W = 2, N = 2, en = 1:
   - wrap_cnt goes 1, 2, 3, 3 (saturated).
   - A load clears it to 0.
